// File: rtl/ram_pkg.sv
// ---------------------------------------------------------------------------
// ram_pkg
// Shared types for the latency-modelled RAM and its initiator-side requester.
//   ramstate_t : status reported by the RAM for the current request.
//   reqstate_t : state encoding of the ram_requester FSM.
// ---------------------------------------------------------------------------
package ram_pkg;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      CAPTURE = 2'd2,
      RESP    = 2'd3
   } reqstate_t;

endpackage

// File: rtl/ram_if.sv
// ---------------------------------------------------------------------------
// ram_if
// Signal bundle between an initiator (cpu modport) and the RAM (ram modport).
//   ramaddr/ramREN/ramWEN/ramstore : request, driven by the initiator
//   ramload/ramstate               : load data and status, driven by the RAM
// ---------------------------------------------------------------------------
interface ram_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10
);
   import ram_pkg::*;

   logic [ADDR_WIDTH-1:0] ramaddr;
   logic                  ramREN;
   logic                  ramWEN;
   logic [DATA_WIDTH-1:0] ramstore;
   logic [DATA_WIDTH-1:0] ramload;
   ramstate_t             ramstate;

   modport cpu (
      output ramaddr, ramREN, ramWEN, ramstore,
      input  ramload, ramstate
   );

   modport ram (
      input  ramaddr, ramREN, ramWEN, ramstore,
      output ramload, ramstate
   );

endinterface

// File: rtl/ram_requester.sv
// ---------------------------------------------------------------------------
// ram_requester
// Initiator-side controller for the latency-modelled RAM. Accepts one
// read/write request at a time, holds it stable on ram_if until the RAM
// reports ACCESS, then returns a single response. A saturating timeout
// counter turns a RAM that never completes into an error response.
//
// Ports
//   CLK, nRST            clock (rising edge), async active-low reset
//   ramif (cpu)          RAM request/response bundle
//   req_valid/req_ready  request handshake; req_wen, req_addr, req_wdata
//   rsp_valid/rsp_ready  response handshake; rsp_rdata, rsp_err
// ---------------------------------------------------------------------------
module ram_requester
   import ram_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int TIMEOUT    = 64
) (
   input  logic                  CLK,
   input  logic                  nRST,
   ram_if.cpu                    ramif,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_wen,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err
);

   localparam int            TW        = $clog2(TIMEOUT) + 1;
   localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] TCNT_MAX  = {TW{1'b1}};

   reqstate_t             r_state;
   reqstate_t             w_state_next;
   logic                  r_wen;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_WIDTH-1:0] r_rsp_rdata;
   logic                  r_rsp_err;
   logic [TW-1:0]         r_tcnt;

   logic                  w_access;
   logic                  w_fail;
   logic                  w_req_ready;
   logic                  w_rsp_valid;
   logic                  w_ren;
   logic                  w_wen;

   // ACCESS is tested first everywhere, so it wins over a same-cycle timeout
   assign w_access = (ramif.ramstate == ACCESS);
   assign w_fail   = (ramif.ramstate == ERROR) || (r_tcnt == TCNT_LAST);

   // State register
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            if (req_valid) w_state_next = REQ;
            else           w_state_next = IDLE;
         end
         REQ: begin
            if (w_access)    w_state_next = CAPTURE;
            else if (w_fail) w_state_next = RESP;
            else             w_state_next = REQ;
         end
         CAPTURE: w_state_next = RESP;
         RESP: begin
            if (rsp_ready) w_state_next = IDLE;
            else           w_state_next = RESP;
         end
         default: w_state_next = IDLE;
      endcase
   end

   // Moore outputs decoded from the state register only
   always_comb begin
      w_req_ready = 1'b0;
      w_rsp_valid = 1'b0;
      w_ren       = 1'b0;
      w_wen       = 1'b0;
      case (r_state)
         IDLE:    w_req_ready = 1'b1;
         REQ: begin
            w_ren = ~r_wen;
            w_wen = r_wen;
         end
         CAPTURE: w_rsp_valid = 1'b0;
         RESP:    w_rsp_valid = 1'b1;
         default: w_req_ready = 1'b0;
      endcase
   end

   // Request latch, timeout counter and response registers
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_wen       <= 1'b0;
         r_addr      <= {ADDR_WIDTH{1'b0}};
         r_wdata     <= {DATA_WIDTH{1'b0}};
         r_tcnt      <= {TW{1'b0}};
         r_rsp_rdata <= {DATA_WIDTH{1'b0}};
         r_rsp_err   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (req_valid) begin
                  r_wen   <= req_wen;
                  r_addr  <= req_addr;
                  r_wdata <= req_wdata;
                  r_tcnt  <= {TW{1'b0}};
               end
            end
            REQ: begin
               if (w_access) begin
                  r_tcnt <= r_tcnt;
               end else if (w_fail) begin
                  r_rsp_rdata <= {DATA_WIDTH{1'b0}};
                  r_rsp_err   <= 1'b1;
               end else if (r_tcnt != TCNT_MAX) begin
                  r_tcnt <= r_tcnt + {{(TW-1){1'b0}}, 1'b1};
               end
            end
            CAPTURE: begin
               // ramload was registered by the RAM on the edge closing ACCESS
               r_rsp_rdata <= r_wen ? {DATA_WIDTH{1'b0}} : ramif.ramload;
               r_rsp_err   <= 1'b0;
            end
            default: begin
               // RESP: response registers hold until the handshake completes
               r_rsp_err <= r_rsp_err;
            end
         endcase
      end
   end

   // Address and store data stay on the bus after the access so the RAM
   // never sees them change while a request is asserted
   assign ramif.ramaddr  = r_addr;
   assign ramif.ramstore = r_wdata;
   assign ramif.ramREN   = w_ren;
   assign ramif.ramWEN   = w_wen;

   assign req_ready = w_req_ready;
   assign rsp_valid = w_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_ram_requester.sv
module tb_ram_requester;
   import ram_pkg::*;

   localparam int DW  = 32;
   localparam int AW  = 10;
   localparam int TO  = 16;
   localparam int LAT = 6;

   logic          CLK = 1'b0;
   logic          nRST = 1'b0;
   logic          req_valid;
   logic          req_ready;
   logic          req_wen;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;

   ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ramif();

   ram_requester #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
      .CLK(CLK), .nRST(nRST), .ramif(ramif),
      .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   // ---------------- RAM stub: ACCESS after LAT+1 stable cycles ----------
   logic [DW-1:0] mem [0:1023];
   int            ram_mode = 0;   // 0 normal, 1 stuck BUSY, 2 ERROR in 3rd REQ cycle
   logic [7:0]    s_cnt;
   logic          s_active;
   logic          s_p_active, s_p_ren, s_p_wen;
   logic [AW-1:0] s_p_addr;
   logic [DW-1:0] s_p_store;

   assign s_active = ramif.ramREN | ramif.ramWEN;

   always_comb begin
      if (!s_active)          ramif.ramstate = FREE;
      else if (ram_mode == 1) ramif.ramstate = BUSY;
      else if (ram_mode == 2) ramif.ramstate = (s_cnt == 8'd2) ? ERROR : BUSY;
      else                    ramif.ramstate = (s_cnt == 8'(LAT + 1)) ? ACCESS : BUSY;
   end

   always @(posedge CLK) begin
      if (!nRST) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 32'h5A00_0000 | 32'(i);
         mem[4]        <= 32'hDEAD_BEEF;
         ramif.ramload <= 32'h0;
         s_cnt         <= 8'd0;
         s_p_active    <= 1'b0;
      end else begin
         s_p_active <= s_active;
         s_p_ren    <= ramif.ramREN;
         s_p_wen    <= ramif.ramWEN;
         s_p_addr   <= ramif.ramaddr;
         s_p_store  <= ramif.ramstore;
         if (!s_active) s_cnt <= 8'd0;
         else if (s_p_active && s_p_ren == ramif.ramREN && s_p_wen == ramif.ramWEN &&
                  s_p_addr == ramif.ramaddr && s_p_store == ramif.ramstore) begin
            if (s_cnt != 8'hFF) s_cnt <= s_cnt + 8'd1;
         end else s_cnt <= 8'd1;
         if (ramif.ramstate == ACCESS) begin
            if (ramif.ramWEN) mem[ramif.ramaddr] <= ramif.ramstore;
            else              ramif.ramload <= mem[ramif.ramaddr];
         end
      end
   end

   // ---------------- bus monitor: stability during request, idle gaps ----
   int   stab_viol = 0;
   int   gap = 1000;
   int   min_gap = 1000;
   logic m_p_active = 1'b0, m_p_ren, m_p_wen;
   logic [AW-1:0] m_p_addr;
   logic [DW-1:0] m_p_store;

   always @(negedge CLK) begin
      if (s_active && m_p_active &&
          (m_p_addr != ramif.ramaddr || m_p_store != ramif.ramstore ||
           m_p_ren != ramif.ramREN || m_p_wen != ramif.ramWEN))
         stab_viol = stab_viol + 1;
      if (!s_active) gap = gap + 1;
      else begin
         if (!m_p_active && gap < min_gap) min_gap = gap;
         gap = 0;
      end
      m_p_active = s_active;
      m_p_ren    = ramif.ramREN;
      m_p_wen    = ramif.ramWEN;
      m_p_addr   = ramif.ramaddr;
      m_p_store  = ramif.ramstore;
   end

   // ---------------- checking helpers and scoreboard ---------------------
   int errors = 0;
   int checks = 0;
   int t0 = 0;

   typedef struct { logic [DW-1:0] rdata; logic err; int lat; } exp_t;
   exp_t sb[$];

   typedef struct {
      logic          wen;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      int            mode;
      logic [DW-1:0] exp_rdata;
      logic          exp_err;
      int            exp_lat;
   } vec_t;
   vec_t vecs[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " req_ready"}, {31'd0, req_ready}, 32'd1);
      chk({tag, " rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
      chk({tag, " rsp_rdata"}, rsp_rdata, 32'd0);
      chk({tag, " rsp_err"},   {31'd0, rsp_err}, 32'd0);
      chk({tag, " ramREN"},    {31'd0, ramif.ramREN}, 32'd0);
      chk({tag, " ramWEN"},    {31'd0, ramif.ramWEN}, 32'd0);
      chk({tag, " ramaddr"},   {22'd0, ramif.ramaddr}, 32'd0);
      chk({tag, " ramstore"},  ramif.ramstore, 32'd0);
   endtask

   // Drive one request at a negedge; returns at the negedge of cycle 1
   task automatic do_req(input logic wen, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic push, input logic [DW-1:0] e_rdata, input logic e_err,
                         input int e_lat);
      int n = 0;
      while (!req_ready && n < 50) begin
         @(negedge CLK);
         n++;
      end
      chk("req_ready before request", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1;
      req_wen   = wen;
      req_addr  = addr;
      req_wdata = wdata;
      t0 = cyc;
      if (push) sb.push_back('{e_rdata, e_err, e_lat});
      @(negedge CLK);
      req_valid = 1'b0;
   endtask

   // Wait (bounded) for rsp_valid, compare against the scoreboard head
   task automatic wait_rsp(input string name, input logic check_idle);
      int   n = 0;
      exp_t e;
      while (!rsp_valid && n < 60) begin
         @(negedge CLK);
         n++;
      end
      chk({name, " rsp_valid seen"}, {31'd0, rsp_valid}, 32'd1);
      if (sb.size() == 0) begin
         chk({name, " scoreboard entry present"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         chk({name, " rsp_rdata"}, rsp_rdata, e.rdata);
         chk({name, " rsp_err"}, {31'd0, rsp_err}, {31'd0, e.err});
         chk({name, " rsp_valid cycle"}, cyc - t0, e.lat);
         if (check_idle) begin
            @(negedge CLK);
            chk({name, " req_ready back"}, {31'd0, req_ready}, 32'd1);
            chk({name, " rsp_valid low"}, {31'd0, rsp_valid}, 32'd0);
            chk({name, " idle cycle"}, cyc - t0, e.lat + 1);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int hi_cnt;
      vecs[0] = '{1'b0, 10'h004, 32'h0,         0, 32'hDEAD_BEEF, 1'b0, LAT + 4};
      vecs[1] = '{1'b1, 10'h010, 32'h1234_5678, 0, 32'h0,         1'b0, LAT + 4};
      vecs[2] = '{1'b0, 10'h010, 32'h0,         0, 32'h1234_5678, 1'b0, LAT + 4};
      vecs[3] = '{1'b0, 10'h020, 32'h0,         0, 32'h5A00_0020, 1'b0, LAT + 4};
      vecs[4] = '{1'b0, 10'h020, 32'h0,         0, 32'h5A00_0020, 1'b0, LAT + 4};
      vecs[5] = '{1'b0, 10'h030, 32'h0,         1, 32'h0,         1'b1, TO + 1};
      vecs[6] = '{1'b1, 10'h040, 32'hFFFF_FFFF, 2, 32'h0,         1'b1, 4};
      vecs[7] = '{1'b0, 10'h040, 32'h0,         0, 32'h5A00_0040, 1'b0, LAT + 4};
      vecs[8] = '{1'b0, 10'h3FF, 32'h0,         0, 32'h5A00_03FF, 1'b0, LAT + 4};

      req_valid = 1'b0;
      req_wen   = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      rsp_ready = 1'b1;
      nRST      = 1'b0;
      repeat (3) @(negedge CLK);
      chk_reset_vals("reset");
      nRST = 1'b1;
      @(negedge CLK);

      for (int i = 0; i < 9; i++) begin
         ram_mode = vecs[i].mode;
         do_req(vecs[i].wen, vecs[i].addr, vecs[i].wdata, 1'b1,
                vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_lat);
         wait_rsp($sformatf("vec%0d", i), 1'b1);
      end

      // Response back-pressure: rsp_ready low for 5 cycles, req_valid ignored
      ram_mode  = 0;
      rsp_ready = 1'b0;
      do_req(1'b0, 10'h004, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, LAT + 4);
      wait_rsp("bp", 1'b0);
      req_valid = 1'b1;
      req_addr  = 10'h123;
      for (int k = 0; k < 5; k++) begin
         @(negedge CLK);
         chk("bp rsp_valid held", {31'd0, rsp_valid}, 32'd1);
         chk("bp rsp_rdata held", rsp_rdata, 32'hDEAD_BEEF);
         chk("bp req_ready low", {31'd0, req_ready}, 32'd0);
      end
      rsp_ready = 1'b1;
      req_valid = 1'b0;
      @(negedge CLK);
      chk("bp released rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("bp released req_ready", {31'd0, req_ready}, 32'd1);
      chk("bp no access started", {31'd0, ramif.ramREN}, 32'd0);

      // Reset pulse during REQ of a write aborts it without a response
      do_req(1'b1, 10'h050, 32'h0BAD_F00D, 1'b0, 32'h0, 1'b0, 0);
      @(negedge CLK);
      @(negedge CLK);
      chk("rst write in REQ", {31'd0, ramif.ramWEN}, 32'd1);
      nRST = 1'b0;
      #1;
      chk_reset_vals("midrst");
      @(negedge CLK);
      nRST = 1'b1;
      hi_cnt = 0;
      for (int k = 0; k < 15; k++) begin
         @(negedge CLK);
         if (rsp_valid) hi_cnt++;
      end
      chk("midrst no response", hi_cnt, 32'd0);
      do_req(1'b0, 10'h050, 32'h0, 1'b1, 32'h5A00_0050, 1'b0, LAT + 4);
      wait_rsp("after_rst", 1'b1);

      chk("request bus stable", stab_viol, 32'd0);
      chk("min idle gap >= 2", {31'd0, (min_gap >= 2)}, 32'd1);
      chk("scoreboard drained", sb.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
